// File: rtl/channel_receiver_pkg.sv
// Shared definitions for the dual-rail channel receiver:
// symbol codes, rail indices, FSM states and the 4-edge decoder.
package channel_receiver_pkg;

    localparam logic [2:0] SYM_NOUGHT = 3'd0;
    localparam logic [2:0] SYM_ONE    = 3'd1;
    localparam logic [2:0] SYM_X0     = 3'd2;
    localparam logic [2:0] SYM_FE     = 3'd3;
    localparam logic [2:0] SYM_FS     = 3'd4;
    localparam logic [2:0] SYM_FD     = 3'd5;

    localparam logic RAIL0 = 1'b0;
    localparam logic RAIL1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ONE_UP,
        ST_BOTH_UP,
        ST_LAST_UP,
        ST_HOLD,
        ST_ERR
    } rx_state_e;

    function automatic logic [2:0] decode4(input logic first, input logic ffall);
        logic [2:0] code;
        unique case ({first, ffall})
            {RAIL0, RAIL1}: code = SYM_X0;
            {RAIL1, RAIL0}: code = SYM_FE;
            {RAIL0, RAIL0}: code = SYM_FS;
            default:        code = SYM_FD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/channel_receiver_rail_sync.sv
// Multi-flop synchroniser for one asynchronous rail input.
// Cleared by the synchronous reset like the rest of the receiver.
module rail_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) r_chain <= '0;
        else     r_chain <= {r_chain[STAGES-2:0], i_d};
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/channel_receiver.sv
// Dual-rail 4-phase channel receiver: synchronises the rails, acks each
// edge, decodes completed sequences and offers them on a valid/ready slot.
module channel_receiver
    import channel_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit0,
    input  logic                 bit1,
    output logic                 ack,
    output logic                 sym_valid,
    input  logic                 sym_ready,
    output logic [2:0]           sym_code,
    output logic                 proto_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic      w_r0;
    logic      w_r1;
    logic [1:0] w_rails;
    logic [1:0] r_prev;
    rx_state_e r_state;
    logic      r_first;
    logic      r_ffall;
    logic [2:0] r_hold_code;

    logic      w_edge;
    logic      w_dbl;
    logic      w_free;
    logic      w_viol;
    logic      w_done;
    logic [2:0] w_code;

    rail_sync #(.STAGES(SYNC_STAGES)) u_sync0 (
        .clk (clk),
        .rst (rst),
        .i_d (bit0),
        .o_q (w_r0)
    );

    rail_sync #(.STAGES(SYNC_STAGES)) u_sync1 (
        .clk (clk),
        .rst (rst),
        .i_d (bit1),
        .o_q (w_r1)
    );

    assign w_rails = {w_r1, w_r0};
    assign w_edge  = |(w_rails ^ r_prev);
    assign w_dbl   = &(w_rails ^ r_prev);
    assign w_free  = !sym_valid || sym_ready;

    always_comb begin
        w_viol = 1'b0;
        w_done = 1'b0;
        w_code = r_hold_code;
        unique case (r_state)
            ST_IDLE: begin
                if (w_rails != 2'b00 && !(w_edge && !w_dbl && r_prev == 2'b00))
                    w_viol = 1'b1;
            end
            ST_ONE_UP: begin
                if (w_edge && w_dbl) begin
                    w_viol = 1'b1;
                end else if (w_edge && w_rails == 2'b00) begin
                    w_done = 1'b1;
                    w_code = (r_first == RAIL1) ? SYM_ONE : SYM_NOUGHT;
                end
            end
            ST_BOTH_UP: begin
                if (w_edge && w_dbl) w_viol = 1'b1;
            end
            ST_LAST_UP: begin
                if (w_edge && (w_dbl || w_rails != 2'b00)) begin
                    w_viol = 1'b1;
                end else if (w_edge) begin
                    w_done = 1'b1;
                    w_code = decode4(r_first, r_ffall);
                end
            end
            ST_HOLD: begin
                if (w_edge)      w_viol = 1'b1;
                else if (w_free) w_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev      <= 2'b00;
            r_state     <= ST_IDLE;
            r_first     <= RAIL0;
            r_ffall     <= RAIL0;
            r_hold_code <= SYM_NOUGHT;
            ack         <= 1'b0;
            sym_valid   <= 1'b0;
            sym_code    <= SYM_NOUGHT;
            proto_err   <= 1'b0;
            err_count   <= '0;
        end else begin
            r_prev    <= w_rails;
            proto_err <= w_viol;
            if (sym_valid && sym_ready) sym_valid <= 1'b0;
            if (w_viol) begin
                ack     <= 1'b0;
                r_state <= ST_ERR;
                if (err_count != '1) err_count <= err_count + 1'b1;
            end else if (w_done) begin
                // A full slot stalls the final ack, holding off the sender
                if (w_free) begin
                    sym_valid <= 1'b1;
                    sym_code  <= w_code;
                    ack       <= ~ack;
                    r_state   <= ST_IDLE;
                end else begin
                    r_hold_code <= w_code;
                    r_state     <= ST_HOLD;
                end
            end else begin
                unique case (r_state)
                    ST_IDLE: if (w_edge) begin
                        r_first <= w_rails[1];
                        ack     <= ~ack;
                        r_state <= ST_ONE_UP;
                    end
                    ST_ONE_UP: if (w_edge) begin
                        ack     <= ~ack;
                        r_state <= ST_BOTH_UP;
                    end
                    ST_BOTH_UP: if (w_edge) begin
                        r_ffall <= w_rails[0];
                        ack     <= ~ack;
                        r_state <= ST_LAST_UP;
                    end
                    ST_ERR: if (w_rails == 2'b00) r_state <= ST_IDLE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_channel_receiver.sv
// Directed bench for channel_receiver: acts as the rail sender and
// checks ack timing, decoded symbols, backpressure and error handling.
module tb_channel_receiver;

    localparam int SYNC_STAGES = 2;
    localparam int ERR_CNT_W   = 8;
    localparam int ERR_MAX     = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 bit0;
    logic                 bit1;
    logic                 ack;
    logic                 sym_valid;
    logic                 sym_ready;
    logic [2:0]           sym_code;
    logic                 proto_err;
    logic [ERR_CNT_W-1:0] err_count;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_err = 0;
    logic [2:0] q[$];

    typedef struct {
        logic       first;
        logic       ffall;
        logic       four;
        logic [2:0] exp;
        string      name;
    } vec_t;

    vec_t vt[6];

    always #5 clk = ~clk;

    channel_receiver #(
        .SYNC_STAGES (SYNC_STAGES),
        .ERR_CNT_W   (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit0      (bit0),
        .bit1      (bit1),
        .ack       (ack),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_code  (sym_code),
        .proto_err (proto_err),
        .err_count (err_count)
    );

    always @(negedge clk)
        if (!rst && sym_valid && sym_ready) q.push_back(sym_code);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_rail(input logic r, input logic v);
        if (r) bit1 = v;
        else   bit0 = v;
    endtask

    task automatic wait_ack(input logic v, input string name);
        int n = 0;
        n_chk++;
        while (ack !== v && n < 30) begin
            tick();
            n++;
        end
        if (ack !== v) begin
            n_fail++;
            $display("FAIL %s: ack=%0b expected %0b within 30 cycles", name, ack, v);
        end
    endtask

    task automatic wait_err(input string name);
        int n = 0;
        n_chk++;
        while (proto_err !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        if (proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: proto_err=%0b expected 1 within 12 cycles", name, proto_err);
        end
    endtask

    task automatic get_sym(input logic [2:0] exp, input string name);
        int n = 0;
        while (q.size() == 0 && n < 12) begin
            tick();
            n++;
        end
        n_chk++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no symbol delivered, expected code %0d", name, exp);
        end else begin
            logic [2:0] got;
            got = q.pop_front();
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: code got %0d expected %0d", name, got, exp);
            end
        end
    endtask

    task automatic send_sym(input logic first, input logic ffall, input logic four);
        set_rail(first, 1'b1);
        wait_ack(1'b1, "ack_rise1");
        if (four) begin
            set_rail(~first, 1'b1);
            wait_ack(1'b0, "ack_fall2");
            set_rail(ffall, 1'b0);
            wait_ack(1'b1, "ack_rise3");
            set_rail(~ffall, 1'b0);
            wait_ack(1'b0, "ack_fall4");
        end else begin
            set_rail(first, 1'b0);
            wait_ack(1'b0, "ack_fall2");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b0, 1'b0, 1'b0, 3'd0, "NOUGHT"};
        vt[1] = '{1'b1, 1'b0, 1'b0, 3'd1, "ONE"};
        vt[2] = '{1'b0, 1'b1, 1'b1, 3'd2, "X0"};
        vt[3] = '{1'b1, 1'b0, 1'b1, 3'd3, "FE"};
        vt[4] = '{1'b0, 1'b0, 1'b1, 3'd4, "FS"};
        vt[5] = '{1'b1, 1'b1, 1'b1, 3'd5, "FD"};

        rst = 1'b1;
        bit0 = 1'b0;
        bit1 = 1'b0;
        sym_ready = 1'b0;
        repeat (3) tick();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_valid", 32'(sym_valid), 32'd0);
        check("rst_code", 32'(sym_code), 32'd0);
        check("rst_perr", 32'(proto_err), 32'd0);
        check("rst_errcnt", 32'(err_count), 32'd0);
        rst = 1'b0;
        tick();

        // NOUGHT with exact ack latency of SYNC_STAGES+1 clocks
        bit0 = 1'b1;
        repeat (SYNC_STAGES) tick();
        check("lat_up_early", 32'(ack), 32'd0);
        tick();
        check("lat_up", 32'(ack), 32'd1);
        bit0 = 1'b0;
        repeat (SYNC_STAGES) tick();
        check("lat_dn_early", 32'(ack), 32'd1);
        check("lat_dn_novalid", 32'(sym_valid), 32'd0);
        tick();
        check("lat_dn", 32'(ack), 32'd0);
        check("nought_valid", 32'(sym_valid), 32'd1);
        check("nought_code", 32'(sym_code), 32'd0);
        sym_ready = 1'b1;
        get_sym(3'd0, "nought_deliver");

        // All symbols back-to-back from the vector table
        for (int i = 0; i < 6; i++) begin
            send_sym(vt[i].first, vt[i].ffall, vt[i].four);
            check({"end_ack_", vt[i].name}, 32'(ack), 32'd0);
            get_sym(vt[i].exp, {"code_", vt[i].name});
        end
        check("tbl_errcnt", 32'(err_count), 32'd0);

        // Backpressure: ONE held in slot, NOUGHT completion stalled
        sym_ready = 1'b0;
        repeat (2) tick();
        send_sym(1'b1, 1'b0, 1'b0);
        check("bp_one_valid", 32'(sym_valid), 32'd1);
        check("bp_one_code", 32'(sym_code), 32'd1);
        bit0 = 1'b1;
        wait_ack(1'b1, "bp_nought_up");
        bit0 = 1'b0;
        repeat (8) tick();
        check("bp_hold_ack", 32'(ack), 32'd1);
        check("bp_hold_code", 32'(sym_code), 32'd1);
        check("bp_hold_valid", 32'(sym_valid), 32'd1);
        sym_ready = 1'b1;
        tick();
        check("bp_rel_ack", 32'(ack), 32'd0);
        check("bp_rel_code", 32'(sym_code), 32'd0);
        check("bp_rel_valid", 32'(sym_valid), 32'd1);
        get_sym(3'd1, "bp_first");
        get_sym(3'd0, "bp_second");

        // Both rails rise together
        bit0 = 1'b1;
        bit1 = 1'b1;
        wait_err("dbl_rise_perr");
        exp_err++;
        check("dbl_rise_cnt", 32'(err_count), 32'(exp_err));
        check("dbl_rise_ack", 32'(ack), 32'd0);
        tick();
        check("perr_pulse", 32'(proto_err), 32'd0);
        bit0 = 1'b0;
        bit1 = 1'b0;
        repeat (6) tick();
        send_sym(1'b0, 1'b0, 1'b1);
        get_sym(3'd4, "post_err_fs");

        // Violation while ack is high forces ack low
        bit0 = 1'b1;
        wait_ack(1'b1, "swap_up");
        bit0 = 1'b0;
        bit1 = 1'b1;
        wait_err("swap_perr");
        exp_err++;
        check("swap_ack", 32'(ack), 32'd0);
        check("swap_cnt", 32'(err_count), 32'(exp_err));
        bit1 = 1'b0;
        repeat (6) tick();
        check("swap_nosym", 32'(q.size()), 32'd0);

        // Reset mid-X0 with rails left high
        bit0 = 1'b1;
        wait_ack(1'b1, "mid_up0");
        bit1 = 1'b1;
        wait_ack(1'b0, "mid_up1");
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_valid", 32'(sym_valid), 32'd0);
        exp_err = 0;
        rst = 1'b0;
        wait_err("residual_perr");
        exp_err++;
        bit0 = 1'b0;
        bit1 = 1'b0;
        repeat (6) tick();
        check("residual_cnt", 32'(err_count), 32'(exp_err));
        send_sym(1'b1, 1'b0, 1'b0);
        get_sym(3'd1, "post_rst_one");

        // Saturation of the error counter
        for (int i = 0; i < (1 << ERR_CNT_W) + 3; i++) begin
            bit0 = 1'b1;
            bit1 = 1'b1;
            repeat (4) tick();
            bit0 = 1'b0;
            bit1 = 1'b0;
            repeat (5) tick();
            exp_err = (exp_err + 1 > ERR_MAX) ? ERR_MAX : exp_err + 1;
        end
        check("sat_cnt", 32'(err_count), 32'(exp_err));
        check("sat_ack", 32'(ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
